fetch: RTL and testbench
========================

// Module: fetch
// PURPOSE
//  Instruction fetch stage directly upstream of execute/decode. Holds the fetch PC and
//  issues word reads on a valid/ready instruction-memory port. Buffers returned words
//  with their PCs in a small prefetch FIFO and presents them in order to decode.
//  Redirects (override/newpc from execute) flush the FIFO and restart fetch at newpc.
// PARAMETERS
//  RESET_PC   32'h00000000  PC of first fetch after reset
//  DEPTH      2             prefetch FIFO entries (power of 2, >=2)
// PORTS
//  clk         in   1   clock, all state on posedge
//  rst         in   1   synchronous reset, ACTIVE-LOW (0 = reset)
//  hlt         in   1   pipeline stall: no pop, no redirect accepted while 1
//  override    in   1   redirect request from execute
//  newpc       in   32  redirect target
//  imem_valid  out  1   fetch request valid
//  imem_ready  in   1   memory accepts request and returns imem_rdata same cycle
//  imem_addr   out  32  fetch address (word aligned)
//  imem_rdata  in   32  fetched instruction word
//  instr_valid out  1   FIFO head valid (FIFO not empty)
//  instr       out  32  FIFO head instruction
//  outpc       out  32  FIFO head PC
//  ifault      out  1   FIFO head carries fetch fault (0 when macro absent)
// BEHAVIOUR
//  - Reset (rst==0 at posedge): pc<=RESET_PC, FIFO empty, state REQ; instr_valid=0,
//    ifault=0. imem_valid may be 1 in the first cycle after rst rises.
//  - States: IDLE (no request), REQ (imem_valid=1, imem_addr=pc),
//    DROP (imem_valid=1, imem_addr=stale addr, response discarded).
//  - imem_valid/imem_addr stay stable from assertion until imem_ready; never withdrawn.
//  - REQ & imem_ready: push {pc,imem_rdata}; pc<=pc+4; stay REQ if count_after<DEPTH,
//    else IDLE. At most one request outstanding; push never hits a full FIFO.
//  - IDLE -> REQ the cycle after count drops below DEPTH.
//  - Pop: instr_valid & !hlt at posedge removes head. Push+pop same cycle: count unchanged.
//  - Redirect (override & !hlt): FIFO flushed (count<=0, pointers reset), pc<=newpc,
//    no pop that cycle. REQ w/o ready -> DROP; REQ with ready -> data discarded, -> REQ;
//    IDLE -> REQ. DROP & imem_ready -> REQ at the redirect pc.
//  - Redirect while DROP: pc<=newpc, stay DROP (latest target wins).
//  - override while hlt=1: ignored; execute re-asserts it after the stall.
//  - First redirected instruction: instr_valid earliest 1 cycle after its imem_ready.
//  - Latency: request->instr_valid = 1 cycle after imem_ready (FIFO registered).
//  - pc arithmetic mod 2^32; 32'hFFFFFFFC+4 wraps to 0, no fault.
//  - newpc[1:0] ignored for addressing: imem_addr={pc[31:2],2'b00} always.
//  - rst==0 mid-request: state and FIFO cleared immediately; the pending response
//    is not tracked further (memory side is reset together).
// CONFIGURATION
//  FETCH_MISALIGN_FAULT_EN defined: redirect with newpc[1:0]!=0 pushes one entry
//    {pc=newpc, instr=32'h00000013, ifault=1} without a memory request, then IDLE
//    until next redirect. Undefined: no check, ifault tied 0, low bits dropped.
// TESTING
//  1 reset, imem_ready=1 always, hlt=0 -> imem_addr 0,4,8,...; outpc/instr in order
//    one cycle behind, instr_valid continuous after first cycle.
//  2 hlt=1 for 5 cycles, DEPTH=2 -> exactly 2 entries buffered, imem_valid=0 (IDLE),
//    head stable; hlt=0 -> pops PCs 0,4 then fetch resumes at 8.
//  3 imem_ready low 3 cycles after req at 0x10, override newpc=0x100 in 2nd cycle ->
//    addr holds 0x10 until ready, 0x10 word never on instr, next addr 0x100.
//  4 override newpc=0x200 same cycle as push and pop -> FIFO empty next cycle,
//    next outpc=0x200.
//  5 pc 0xFFFFFFFC fetched -> next imem_addr 0x00000000.
//  6 (FETCH_MISALIGN_FAULT_EN) override newpc=0x102 -> outpc=0x102, ifault=1,
//    no imem_valid until next redirect; macro off -> imem_addr 0x100, ifault=0.

Source files
------------

// File: rtl/fetch.sv
// Instruction fetch stage: PC register, single-outstanding imem request and a prefetch FIFO.
// Optional FETCH_MISALIGN_FAULT_EN: misaligned redirect targets produce a faulting NOP entry.
module fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        hlt,
  input  logic        override,
  input  logic [31:0] newpc,
  output logic        imem_valid,
  input  logic        imem_ready,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] outpc,
  output logic        ifault
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_DROP = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [31:0]   pc_q, pc_d;
  logic [31:0]   drop_addr_q, drop_addr_d;
  logic [PW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [31:0]   fifo_pc_q [DEPTH];
  logic [31:0]   fifo_pc_d [DEPTH];
  logic [31:0]   fifo_instr_q [DEPTH];
  logic [31:0]   fifo_instr_d [DEPTH];

  logic        redirect, pop, push, hold, misalign;
  logic [31:0] fetch_addr, target_pc;

`ifdef FETCH_MISALIGN_FAULT_EN
  logic fifo_fault_q [DEPTH];
  logic fifo_fault_d [DEPTH];
  logic hold_q, hold_d;

  // After a faulting redirect, fetch parks until execute steers elsewhere.
  assign hold     = hold_q;
  assign misalign = newpc[1:0] != 2'b00;
  assign ifault   = instr_valid & fifo_fault_q[rptr_q];
`else
  assign hold     = 1'b0;
  assign misalign = 1'b0;
  assign ifault   = 1'b0;
`endif

  assign fetch_addr  = pc_q & 32'hFFFF_FFFC;
  assign target_pc   = newpc & 32'hFFFF_FFFC;
  assign imem_valid  = state_q != ST_IDLE;
  assign imem_addr   = (state_q == ST_DROP) ? drop_addr_q : fetch_addr;
  assign instr_valid = count_q != '0;
  assign instr       = fifo_instr_q[rptr_q];
  assign outpc       = fifo_pc_q[rptr_q];

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    drop_addr_d  = drop_addr_q;
    wptr_d       = wptr_q;
    rptr_d       = rptr_q;
    count_d      = count_q;
    fifo_pc_d    = fifo_pc_q;
    fifo_instr_d = fifo_instr_q;
`ifdef FETCH_MISALIGN_FAULT_EN
    fifo_fault_d = fifo_fault_q;
    hold_d       = hold_q;
`endif
    redirect = override & ~hlt;
    pop      = instr_valid & ~hlt & ~redirect;
    push     = (state_q == ST_REQ) & imem_ready & ~redirect;

    if (redirect) begin
      pc_d    = misalign ? newpc : target_pc;
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
      // A request already on the bus cannot be withdrawn, so its response is swallowed in DROP.
      case (state_q)
        ST_REQ: begin
          if (!imem_ready) begin
            state_d     = ST_DROP;
            drop_addr_d = fetch_addr;
          end
        end
        ST_DROP: if (imem_ready) state_d = ST_REQ;
        default: state_d = ST_REQ;
      endcase
      if (misalign && state_d == ST_REQ) state_d = ST_IDLE;
`ifdef FETCH_MISALIGN_FAULT_EN
      hold_d = misalign;
      if (misalign) begin
        fifo_pc_d[0]    = newpc;
        fifo_instr_d[0] = 32'h0000_0013;
        fifo_fault_d[0] = 1'b1;
        wptr_d          = PW'(1);
        count_d         = CW'(1);
      end
`endif
    end else begin
      if (push) begin
        fifo_pc_d[wptr_q]    = fetch_addr;
        fifo_instr_d[wptr_q] = imem_rdata;
`ifdef FETCH_MISALIGN_FAULT_EN
        fifo_fault_d[wptr_q] = 1'b0;
`endif
        wptr_d = wptr_q + PW'(1);
        pc_d   = fetch_addr + 32'd4;
      end
      if (pop) rptr_d = rptr_q + PW'(1);
      count_d = count_q + CW'(push) - CW'(pop);
      case (state_q)
        ST_IDLE: if (!hold && count_d < FULL) state_d = ST_REQ;
        ST_REQ:  if (imem_ready && count_d == FULL) state_d = ST_IDLE;
        ST_DROP: if (imem_ready) state_d = hold ? ST_IDLE : ST_REQ;
        default: state_d = ST_REQ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= ST_REQ;
      pc_q        <= RESET_PC;
      drop_addr_q <= '0;
      wptr_q      <= '0;
      rptr_q      <= '0;
      count_q     <= '0;
`ifdef FETCH_MISALIGN_FAULT_EN
      hold_q      <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      drop_addr_q <= drop_addr_d;
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      count_q     <= count_d;
`ifdef FETCH_MISALIGN_FAULT_EN
      hold_q      <= hold_d;
`endif
    end
  end

  // Payload storage needs no reset; validity is tracked by count_q.
  always_ff @(posedge clk) begin
    fifo_pc_q    <= fifo_pc_d;
    fifo_instr_q <= fifo_instr_d;
`ifdef FETCH_MISALIGN_FAULT_EN
    fifo_fault_q <= fifo_fault_d;
`endif
  end

endmodule

// File: tb/tb_fetch.sv
// Self-checking bench for fetch: scoreboard of expected FIFO entries plus directed scenarios.
module tb_fetch;

  logic        clk = 1'b0;
  logic        rst, hlt, override, imem_ready;
  logic [31:0] newpc, imem_rdata, imem_addr, instr, outpc;
  logic        imem_valid, instr_valid, ifault;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] word;
    logic        fault;
  } entry_t;

  entry_t      sb[$];
  logic [31:0] exp_pc;
  logic        stale, hold;
  int          errors, checks;

  always #5 clk = ~clk;

  fetch #(.RESET_PC(32'h0), .DEPTH(2)) dut (
    .clk(clk), .rst(rst), .hlt(hlt), .override(override), .newpc(newpc),
    .imem_valid(imem_valid), .imem_ready(imem_ready), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .instr_valid(instr_valid), .instr(instr),
    .outpc(outpc), .ifault(ifault)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {~a[15:0], a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  assign imem_rdata = mem_word(imem_addr);

  // Checks the FIFO head against the scoreboard, updates the model for this edge, then advances.
  task automatic tick();
    logic redir, popc, pushc;
    if (!rst) begin
      sb.delete();
      exp_pc = 32'h0;
      stale  = 1'b0;
      hold   = 1'b0;
    end else begin
      checks++;
      if (instr_valid !== (sb.size() != 0)) begin
        errors++;
        $display("[TB] FAIL head_valid: got %b expected %b", instr_valid, sb.size() != 0);
      end
      if (instr_valid === 1'b1 && sb.size() != 0) begin
        checks++;
        if ({outpc, instr, ifault} !== {sb[0].pc, sb[0].word, sb[0].fault}) begin
          errors++;
          $display("[TB] FAIL head_entry: got pc=%h instr=%h f=%b expected pc=%h instr=%h f=%b",
                   outpc, instr, ifault, sb[0].pc, sb[0].word, sb[0].fault);
        end
      end
      if (imem_valid === 1'b1 && !stale && !hold) begin
        checks++;
        if (imem_addr !== exp_pc) begin
          errors++;
          $display("[TB] FAIL fetch_addr: got %h expected %h", imem_addr, exp_pc);
        end
      end
      redir = override && !hlt;
      popc  = (sb.size() != 0) && !hlt && !redir;
      pushc = imem_valid && imem_ready && !redir && !stale && !hold;
      if (popc) void'(sb.pop_front());
      if (pushc) begin
        sb.push_back('{exp_pc, mem_word(exp_pc), 1'b0});
        exp_pc = exp_pc + 32'd4;
      end
      if (redir) begin
        stale = imem_valid && !imem_ready;
        sb.delete();
        exp_pc = newpc & 32'hFFFF_FFFC;
        hold   = 1'b0;
`ifdef FETCH_MISALIGN_FAULT_EN
        if (newpc[1:0] != 2'b00) begin
          hold = 1'b1;
          sb.push_back('{newpc, 32'h0000_0013, 1'b1});
        end
`endif
      end else if (imem_ready) begin
        stale = 1'b0;
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic apply_reset();
    rst = 1'b0;
    tick();
    tick();
    rst = 1'b1;
  endtask

  task automatic test_reset();
    imem_ready = 1'b0;
    apply_reset();
    checks += 3;
    if (instr_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_instr_valid: got %b expected 0", instr_valid); end
    if (ifault !== 1'b0) begin errors++; $display("[TB] FAIL reset_ifault: got %b expected 0", ifault); end
    if (imem_addr !== 32'h0) begin errors++; $display("[TB] FAIL reset_addr: got %h expected 00000000", imem_addr); end
  endtask

  task automatic test_stream();
    imem_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (imem_valid !== 1'b1 || imem_addr !== 32'(i * 4)) begin
        errors++;
        $display("[TB] FAIL stream_addr: got v=%b %h expected v=1 %h", imem_valid, imem_addr, 32'(i * 4));
      end
      if (i > 0) begin
        checks++;
        if (instr_valid !== 1'b1 || outpc !== 32'((i - 1) * 4)) begin
          errors++;
          $display("[TB] FAIL stream_head: got v=%b %h expected v=1 %h", instr_valid, outpc, 32'((i - 1) * 4));
        end
      end
      tick();
    end
  endtask

  task automatic test_hlt_fill();
    apply_reset();
    hlt = 1'b1;
    imem_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      if (k > 0) begin
        checks++;
        if (outpc !== 32'h0) begin errors++; $display("[TB] FAIL hlt_head_stable: got %h expected 00000000", outpc); end
      end
      tick();
    end
    checks += 2;
    if (imem_valid !== 1'b0) begin errors++; $display("[TB] FAIL hlt_idle: got %b expected 0", imem_valid); end
    if (instr_valid !== 1'b1 || outpc !== 32'h0) begin
      errors++; $display("[TB] FAIL hlt_head: got v=%b %h expected v=1 00000000", instr_valid, outpc);
    end
    hlt = 1'b0;
    tick();
    checks += 2;
    if (outpc !== 32'h4) begin errors++; $display("[TB] FAIL hlt_second: got %h expected 00000004", outpc); end
    if (imem_valid !== 1'b1 || imem_addr !== 32'h8) begin
      errors++; $display("[TB] FAIL hlt_resume: got v=%b %h expected v=1 00000008", imem_valid, imem_addr);
    end
    tick();
    checks++;
    if (outpc !== 32'h8) begin errors++; $display("[TB] FAIL hlt_third: got %h expected 00000008", outpc); end
  endtask

  task automatic test_redirect_stall();
    apply_reset();
    imem_ready = 1'b1;
    for (int k = 0; k < 4; k++) tick();
    imem_ready = 1'b0;
    checks++;
    if (imem_addr !== 32'h10) begin errors++; $display("[TB] FAIL stall_addr: got %h expected 00000010", imem_addr); end
    tick();
    override = 1'b1;
    newpc = 32'h100;
    tick();
    override = 1'b0;
    checks += 2;
    if (imem_valid !== 1'b1 || imem_addr !== 32'h10) begin
      errors++; $display("[TB] FAIL drop_hold: got v=%b %h expected v=1 00000010", imem_valid, imem_addr);
    end
    if (instr_valid !== 1'b0) begin errors++; $display("[TB] FAIL drop_flush: got %b expected 0", instr_valid); end
    tick();
    imem_ready = 1'b1;
    checks++;
    if (imem_addr !== 32'h10) begin errors++; $display("[TB] FAIL drop_hold2: got %h expected 00000010", imem_addr); end
    tick();
    checks += 2;
    if (imem_addr !== 32'h100) begin errors++; $display("[TB] FAIL drop_next: got %h expected 00000100", imem_addr); end
    if (instr_valid !== 1'b0) begin errors++; $display("[TB] FAIL drop_discard: got %b expected 0", instr_valid); end
    tick();
    checks++;
    if (instr_valid !== 1'b1 || outpc !== 32'h100) begin
      errors++; $display("[TB] FAIL redirect_head: got v=%b %h expected v=1 00000100", instr_valid, outpc);
    end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (instr_valid === 1'b1 && outpc === 32'h10) begin errors++; $display("[TB] FAIL stale_word: got 00000010 expected not 00000010"); end
      tick();
    end
  endtask

  task automatic test_redirect_pushpop();
    imem_ready = 1'b1;
    override = 1'b1;
    newpc = 32'h200;
    tick();
    override = 1'b0;
    checks += 2;
    if (instr_valid !== 1'b0) begin errors++; $display("[TB] FAIL pushpop_flush: got %b expected 0", instr_valid); end
    if (imem_addr !== 32'h200) begin errors++; $display("[TB] FAIL pushpop_addr: got %h expected 00000200", imem_addr); end
    tick();
    checks++;
    if (instr_valid !== 1'b1 || outpc !== 32'h200) begin
      errors++; $display("[TB] FAIL pushpop_head: got v=%b %h expected v=1 00000200", instr_valid, outpc);
    end
  endtask

  task automatic test_wrap();
    override = 1'b1;
    newpc = 32'hFFFF_FFF8;
    tick();
    override = 1'b0;
    tick();
    checks++;
    if (imem_addr !== 32'hFFFF_FFFC) begin errors++; $display("[TB] FAIL wrap_last: got %h expected fffffffc", imem_addr); end
    tick();
    checks += 2;
    if (imem_addr !== 32'h0) begin errors++; $display("[TB] FAIL wrap_addr: got %h expected 00000000", imem_addr); end
    if (outpc !== 32'hFFFF_FFFC) begin errors++; $display("[TB] FAIL wrap_head: got %h expected fffffffc", outpc); end
    tick();
    checks++;
    if (outpc !== 32'h0) begin errors++; $display("[TB] FAIL wrap_head0: got %h expected 00000000", outpc); end
  endtask

  task automatic test_misalign();
    imem_ready = 1'b1;
    override = 1'b1;
    newpc = 32'h102;
    tick();
    override = 1'b0;
`ifdef FETCH_MISALIGN_FAULT_EN
    checks += 2;
    if (instr_valid !== 1'b1 || outpc !== 32'h102 || ifault !== 1'b1 || instr !== 32'h13) begin
      errors++;
      $display("[TB] FAIL misalign_entry: got v=%b pc=%h f=%b i=%h expected v=1 pc=00000102 f=1 i=00000013",
               instr_valid, outpc, ifault, instr);
    end
    if (imem_valid !== 1'b0) begin errors++; $display("[TB] FAIL misalign_idle: got %b expected 0", imem_valid); end
    for (int k = 0; k < 4; k++) begin
      tick();
      checks++;
      if (imem_valid !== 1'b0) begin errors++; $display("[TB] FAIL misalign_park: got %b expected 0", imem_valid); end
    end
    override = 1'b1;
    newpc = 32'h300;
    tick();
    override = 1'b0;
    checks++;
    if (imem_valid !== 1'b1 || imem_addr !== 32'h300) begin
      errors++; $display("[TB] FAIL misalign_resume: got v=%b %h expected v=1 00000300", imem_valid, imem_addr);
    end
`else
    checks += 2;
    if (imem_valid !== 1'b1 || imem_addr !== 32'h100) begin
      errors++; $display("[TB] FAIL misalign_addr: got v=%b %h expected v=1 00000100", imem_valid, imem_addr);
    end
    if (instr_valid !== 1'b0) begin errors++; $display("[TB] FAIL misalign_flush: got %b expected 0", instr_valid); end
    tick();
    checks++;
    if (outpc !== 32'h100 || ifault !== 1'b0) begin
      errors++; $display("[TB] FAIL misalign_head: got %h f=%b expected 00000100 f=0", outpc, ifault);
    end
`endif
    tick();
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 300; k++) begin
      hlt        = ($urandom_range(0, 3) == 0);
      imem_ready = ($urandom_range(0, 2) != 0);
      override   = ($urandom_range(0, 15) == 0);
      newpc      = {22'h0, 8'($urandom_range(0, 255)), 2'b00};
      tick();
    end
    hlt = 1'b0;
    override = 1'b0;
    imem_ready = 1'b1;
    for (int k = 0; k < 4; k++) tick();
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst = 1'b0;
    hlt = 1'b0;
    override = 1'b0;
    newpc = 32'h0;
    imem_ready = 1'b0;
    exp_pc = 32'h0;
    stale = 1'b0;
    hold = 1'b0;
    test_reset();
    test_stream();
    test_hlt_fill();
    test_redirect_stall();
    test_redirect_pushpop();
    test_wrap();
    test_misalign();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
